// File: rtl/rdyval_arb_pkg.sv
// Shared types and round-robin helpers for
// ready/valid to two-phase channel arbiters.
package rdyval_arb_pkg;

  localparam int MAXN = 16;
  localparam int IDXW = 4;

  typedef struct packed {
    logic            found;
    logic [IDXW-1:0] idx;
  } pick_t;

  // Next pointer after granting g, wrapped at n.
  // An out-of-range g leaves the pointer alone.
  function automatic logic [IDXW-1:0] rr_next(
    input logic [IDXW-1:0] ptr,
    input logic [IDXW-1:0] g,
    input int              n
  );
    logic [IDXW-1:0] nx;
    if (int'(g) >= n)
      nx = ptr;
    else if (int'(g) + 1 == n)
      nx = '0;
    else
      nx = g + 1'b1;
    return nx;
  endfunction

  // First set vld bit at or above ptr, wrapping.
  // Unused upper vld bits are zero, so wrapping at
  // MAXN gives the same winner as wrapping at NREQ.
  function automatic pick_t rr_pick(
    input logic [MAXN-1:0] vld,
    input logic [IDXW-1:0] ptr
  );
    pick_t           p;
    logic [IDXW-1:0] k;
    p = '0;
    for (int i = 0; i < MAXN; i++) begin
      k = ptr + IDXW'(i);
      if (!p.found && vld[k]) begin
        p.found = 1'b1;
        p.idx   = k;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/rdyval_rr_arb_tph_rr_arbiter.sv
// Round-robin pick plus priority pointer.
// vld_i in, gnt_o/found_o out; advance_i moves ptr past gnt.
import rdyval_arb_pkg::*;

module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] vld_i,
  input  logic            advance_i,
  output logic [IDW-1:0]  gnt_o,
  output logic            found_o
);

  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] ptr_d;
  pick_t          pk;

  always_comb pk = rr_pick(MAXN'(vld_i), IDXW'(ptr_q));

  assign gnt_o   = IDW'(pk.idx);
  assign found_o = pk.found;

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i)
      ptr_d = IDW'(rr_next(IDXW'(ptr_q), pk.idx, NREQ));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/rdyval_rr_arb_tph.sv
// NREQ ready/valid producers share one two-phase req/ack channel.
// Ports: vld/rdy/i_dat per producer; req/ack/o_dat/o_id/busy/err out.
import rdyval_arb_pkg::*;

module rdyval_rr_arb_tph #(
  parameter  int NREQ        = 4,
  parameter  int DWIDTH      = 8,
  parameter  bit INCLUDE_CDC = 1'b0,
  localparam int IDW         = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   vld,
  output logic [NREQ-1:0]   rdy,
  input  logic [DWIDTH-1:0] i_dat [NREQ],
  output logic              req,
  input  logic              ack,
  output logic [DWIDTH-1:0] o_dat,
  output logic [IDW-1:0]    o_id,
  output logic              busy,
  output logic              err
);

  logic              ack_i;
  logic              ack_q;
  logic              req_q, req_d;
  logic              err_q, err_d;
  logic [IDW-1:0]    id_q, id_d;
  logic [DWIDTH-1:0] dat_q;
  logic [IDW-1:0]    gnt;
  logic              found;
  logic              idle;
  logic              accept;

  generate
    if (INCLUDE_CDC) begin : g_cdc
      logic [1:0] sync_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[0], ack};
      end
      assign ack_i = sync_q[1];
    end else begin : g_nocdc
      assign ack_i = ack;
    end
  endgenerate

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .vld_i     (vld),
    .advance_i (accept),
    .gnt_o     (gnt),
    .found_o   (found)
  );

  assign idle   = (req_q == ack_i);
  assign accept = idle & found;
  assign rdy    = accept ? (NREQ'(1) << gnt) : '0;

  // Ack moving while ack_q already matched req
  // means the receiver toggled with nothing pending.
  always_comb begin
    req_d = req_q;
    id_d  = id_q;
    err_d = err_q
          | ((ack_i != ack_q) & (req_q == ack_q));
    if (accept) begin
      req_d = ~req_q;
      id_d  = gnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= 1'b0;
      id_q  <= '0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      req_q <= req_d;
      id_q  <= id_d;
      ack_q <= ack_i;
      err_q <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) dat_q <= i_dat[gnt];
  end

  assign req   = req_q;
  assign o_dat = dat_q;
  assign o_id  = id_q;
  assign busy  = req_q ^ ack_i;
  assign err   = err_q;

endmodule

// File: tb/tb_rdyval_rr_arb_tph.sv
// Scoreboard bench: 4-way plain instance and
// 3-way instance with the ack synchronizer.
module tb_rdyval_rr_arb_tph;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;

  logic [3:0] vld0, rdy0;
  logic [7:0] dat0 [4];
  logic       req0, ack0;
  logic [7:0] odat0;
  logic [1:0] oid0;
  logic       busy0, err0;

  logic [2:0] vld1, rdy1;
  logic [7:0] dat1 [3];
  logic       req1, ack1;
  logic [7:0] odat1;
  logic [1:0] oid1;
  logic       busy1, err1;

  int         nchk = 0;
  int         nerr = 0;
  int         mptr [2];
  logic [9:0] sb [$];

  rdyval_rr_arb_tph #(
    .NREQ(4), .DWIDTH(8), .INCLUDE_CDC(1'b0)
  ) u0 (
    .clk(clk), .rst_n(rst_n),
    .vld(vld0), .rdy(rdy0), .i_dat(dat0),
    .req(req0), .ack(ack0),
    .o_dat(odat0), .o_id(oid0),
    .busy(busy0), .err(err0)
  );

  rdyval_rr_arb_tph #(
    .NREQ(3), .DWIDTH(8), .INCLUDE_CDC(1'b1)
  ) u1 (
    .clk(clk), .rst_n(rst_n),
    .vld(vld1), .rdy(rdy1), .i_dat(dat1),
    .req(req1), .ack(ack1),
    .o_dat(odat1), .o_id(oid1),
    .busy(busy1), .err(err1)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int mpick(
    input logic [3:0] v, input int p, input int n
  );
    for (int k = 0; k < n; k++)
      if (v[(p + k) % n]) return (p + k) % n;
    return -1;
  endfunction

  // Called at a negedge while idle: check rdy,
  // push expectation, wait for req, pop and compare.
  task automatic grant(input int u);
    int         g, n;
    logic [3:0] v, r;
    logic [9:0] e, o;
    bit         seen;
    n = (u != 0) ? 3 : 4;
    v = (u != 0) ? {1'b0, vld1} : vld0;
    r = (u != 0) ? {1'b0, rdy1} : rdy0;
    g = mpick(v, mptr[u], n);
    check($sformatf("rdy%0d", u), 32'(r),
          (g < 0) ? 32'd0 : (32'd1 << g));
    if ((r & v) != 0) begin
      if (g < 0) e = '1;
      else e = {g[1:0], (u != 0) ? dat1[g] : dat0[g]};
      sb.push_back(e);
      mptr[u] = (g + 1) % n;
    end
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge clk);
      seen = (u != 0) ? (req1 != ack1) : (req0 != ack0);
    end
    check($sformatf("req_tgl%0d", u), 32'(seen), 1);
    if (sb.size() == 0) begin
      check($sformatf("sb_empty%0d", u), 1, 0);
    end else begin
      e = sb.pop_front();
      o = (u != 0) ? {oid1, odat1} : {oid0, odat0};
      check($sformatf("id_dat%0d", u), 32'(o), 32'(e));
    end
    r = (u != 0) ? {1'b0, rdy1} : rdy0;
    check($sformatf("busy_rdy%0d", u),
          32'({((u != 0) ? busy1 : busy0), r}),
          32'h10);
  endtask

  // Receiver: toggle ack after dly cycles, end at
  // the first negedge where the channel is idle.
  task automatic ack_back(input int u, input int dly);
    repeat (dly) @(posedge clk);
    #1;
    if (u == 0) begin
      ack0 = ~ack0;
      @(negedge clk);
      check("idle0", 32'(busy0), 0);
    end else begin
      ack1 = ~ack1;
      @(negedge clk);
      check("cdc_m0", 32'(busy1), 1);
      @(negedge clk);
      check("cdc_m1", 32'(busy1), 1);
      @(negedge clk);
      check("cdc_m2", 32'(busy1), 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    vld0 = '0; vld1 = '0;
    ack0 = 1'b0; ack1 = 1'b0;
    mptr[0] = 0; mptr[1] = 0;
    for (int i = 0; i < 4; i++) dat0[i] = 8'($urandom);
    for (int i = 0; i < 3; i++) dat1[i] = 8'($urandom);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_req", 32'(req0), 0);
    check("rst_id", 32'(oid0), 0);
    check("rst_busy", 32'(busy0), 0);
    check("rst_err", 32'(err0), 0);
    check("rst_rdy", 32'(rdy0), 0);

    @(posedge clk);
    #1 vld0 = 4'hF;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      grant(0);
      if (i == 4) vld0 = '0;
      ack_back(0, 3);
    end
    check("rdy_none", 32'(rdy0), 0);

    @(posedge clk);
    #1 ack0 = ~ack0;
    @(negedge clk);
    check("err_pre", 32'(err0), 0);
    @(negedge clk);
    check("err_set", 32'(err0), 1);
    @(posedge clk);
    #1 ack0 = ~ack0;
    @(negedge clk);
    check("err_keep", 32'(err0), 1);

    @(posedge clk);
    #1 vld0 = 4'b0110;
    @(negedge clk);
    grant(0);
    ack_back(0, 2);
    grant(0);
    check("err_hold", 32'(err0), 1);
    check("pre_rst_busy", 32'(busy0), 1);

    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_req", 32'(req0), 0);
    check("arst_busy", 32'(busy0), 0);
    check("arst_id", 32'(oid0), 0);
    check("arst_err", 32'(err0), 0);
    vld0 = '0;
    ack0 = 1'b0;
    mptr[0] = 0; mptr[1] = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    @(posedge clk);
    #1 vld1 = 3'b111;
    @(negedge clk);
    grant(1);
    ack_back(1, 2);
    grant(1);
    vld1 = 3'b011;
    ack_back(1, 2);
    grant(1);
    ack_back(1, 2);
    grant(1);
    vld1 = '0;
    ack_back(1, 2);
    check("rdy1_none", 32'(rdy1), 0);
    check("err1", 32'(err1), 0);

    $display("Result: errors=%0d of %0d checks",
             nerr, nchk);
    $finish;
  end

endmodule
